// File: rtl/sync_gearbox_fifo_pkg.sv
// Shared defaults, derived sizes and lane helpers for the narrow-to-wide gearbox FIFO.
package sync_gearbox_fifo_pkg;

  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned ASIZE_DEF = 4;
  localparam int unsigned RLOG2_DEF = 2;

  localparam int unsigned DEPTH = 2 ** ASIZE_DEF;
  localparam int unsigned RATIO = 2 ** RLOG2_DEF;
  localparam int unsigned CW    = ASIZE_DEF + 1;

  // Valid-lane mask with the first n lanes set, lane 0 in the MSB bit.
  function automatic logic [31:0] lane_mask(input int unsigned n, input int unsigned ratio);
    lane_mask = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < ratio && i < n) lane_mask[5'(ratio - 1 - i)] = 1'b1;
    end
  endfunction

  // Entries consumed by a read: a full word, or the residual tail while flushing.
  function automatic int unsigned take_size(input int unsigned cnt, input logic fp,
                                            input int unsigned ratio);
    if (cnt >= ratio) take_size = ratio;
    else if (fp)      take_size = cnt;
    else              take_size = 0;
  endfunction

endpackage

// File: rtl/sync_gearbox_fifo_ram.sv
// Entry storage: one synchronous write port, RATIO combinational read lanes at wrapped addresses.
module sync_gearbox_fifo_ram
  import sync_gearbox_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned ASIZE = ASIZE_DEF,
  parameter int unsigned RLOG2 = RLOG2_DEF
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ASIZE-1:0]              waddr,
  input  logic [DSIZE-1:0]              wdata,
  input  logic [ASIZE-1:0]              raddr,
  output logic [DSIZE*(2**RLOG2)-1:0]   lanes
);

  localparam int unsigned DEP = 2 ** ASIZE;
  localparam int unsigned RAT = 2 ** RLOG2;
  localparam int unsigned WW  = DSIZE * RAT;

  logic [DSIZE-1:0] mem [DEP];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Lane 0 (oldest) lands in the MSB slice; addresses wrap modulo DEPTH.
  always_comb begin
    lanes = '0;
    for (int i = 0; i < int'(RAT); i++) begin
      lanes[WW-1-i*DSIZE -: DSIZE] = mem[raddr + ASIZE'(i)];
    end
  end

endmodule

// File: rtl/sync_gearbox_fifo.sv
// Single-clock width-converting FIFO: DSIZE-bit writes, RATIO-lane registered reads with flush drain.
module sync_gearbox_fifo
  import sync_gearbox_fifo_pkg::*;
#(
  parameter int unsigned     DSIZE    = DSIZE_DEF,
  parameter int unsigned     ASIZE    = ASIZE_DEF,
  parameter int unsigned     RLOG2    = RLOG2_DEF,
  parameter int unsigned     AF_LEVEL = 12,
  parameter logic [DSIZE-1:0] FILL    = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wren,
  input  logic [DSIZE-1:0]            wdata,
  output logic                        wfull,
  output logic                        walmost_full,
  input  logic                        rden,
  output logic                        rdready,
  output logic [DSIZE*(2**RLOG2)-1:0] rdata,
  output logic [(2**RLOG2)-1:0]       rmask,
  output logic                        rvalid,
  input  logic                        flush,
  output logic [ASIZE:0]              count
);

  localparam int unsigned DEP = 2 ** ASIZE;
  localparam int unsigned RAT = 2 ** RLOG2;
  localparam int unsigned CWL = ASIZE + 1;
  localparam int unsigned WW  = DSIZE * RAT;

  logic [ASIZE-1:0] wptr;
  logic [ASIZE-1:0] rptr;
  logic             flush_pending;
  logic             flush_pending_next;
  logic [CWL-1:0]   count_next;
  logic [CWL-1:0]   take;
  logic [RAT-1:0]   take_mask;
  logic [WW-1:0]    lanes;
  logic [WW-1:0]    word_c;
  logic             wacc;
  logic             racc;

  sync_gearbox_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .RLOG2 (RLOG2)
  ) u_ram (
    .clk   (clk),
    .we    (wacc),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .lanes (lanes)
  );

  assign rdready = (count >= CWL'(RAT)) || (flush_pending && (count != '0));
  assign wacc    = wren && !wfull;
  assign racc    = rden && rdready;

  // Take size uses the pre-update count, so a same-cycle write is never read.
  always_comb begin
    take               = CWL'(take_size(32'(count), flush_pending, RAT));
    take_mask          = RAT'(lane_mask(32'(take), RAT));
    count_next         = count + CWL'(wacc) - (racc ? take : '0);
    flush_pending_next = flush_pending;
    if (count_next == '0)       flush_pending_next = 1'b0;
    else if (flush)             flush_pending_next = 1'b1;
    word_c = '0;
    for (int i = 0; i < int'(RAT); i++) begin
      word_c[WW-1-i*DSIZE -: DSIZE] = take_mask[RAT-1-i] ? lanes[WW-1-i*DSIZE -: DSIZE] : FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
      wfull         <= 1'b0;
      walmost_full  <= 1'b0;
      rvalid        <= 1'b0;
      rdata         <= {RAT{FILL}};
      rmask         <= '0;
    end else begin
      if (wacc) wptr <= wptr + 1'b1;
      if (racc) begin
        rptr  <= rptr + ASIZE'(take);
        rdata <= word_c;
        rmask <= take_mask;
      end
      count         <= count_next;
      flush_pending <= flush_pending_next;
      wfull         <= (count_next == CWL'(DEP)) || flush_pending_next;
      walmost_full  <= count_next >= CWL'(AF_LEVEL);
      rvalid        <= racc;
    end
  end

endmodule
